// File: rtl/pwm_mode_ctrl_if.sv
// Signal bundle between the PWM mode sequencer and its controller / PWM generator.
// slave = the sequencer (pwm_mode_ctrl), master = whoever drives commands and config.
interface pwm_mode_ctrl_if;
  // Handshake: there is no valid/ready pair. Commands are levels sampled on
  // every rising clk edge, cfg_wr is a one-cycle strobe that is always accepted,
  // and every status output is registered (visible one cycle after its cause).
  logic        cmd_check;
  logic        cmd_start;
  logic        cmd_stop;
  logic        cmd_clear;
  logic        fault_in;
  logic        cfg_wr;
  logic [15:0] pose_req;
  logic [15:0] nege_req;
  logic [15:0] fre_req;
  logic [15:0] comp_tri;
  logic [3:0]  col;

  logic        start;
  logic        check;
  logic        pass;
  logic        syn;
  logic [15:0] pose;
  logic [15:0] nege;
  logic [15:0] fre;
  logic [2:0]  state;
  logic        check_ok;
  logic [3:0]  check_err;
  logic        cfg_pend;

  modport slave (
    input  cmd_check, cmd_start, cmd_stop, cmd_clear, fault_in, cfg_wr,
           pose_req, nege_req, fre_req, comp_tri, col,
    output start, check, pass, syn, pose, nege, fre, state,
           check_ok, check_err, cfg_pend
  );

  modport master (
    output cmd_check, cmd_start, cmd_stop, cmd_clear, fault_in, cfg_wr,
           pose_req, nege_req, fre_req, comp_tri, col,
    input  start, check, pass, syn, pose, nege, fre, state,
           check_ok, check_err, cfg_pend
  );
endinterface

// File: rtl/pwm_mode_ctrl.sv
// Mode sequencer and config shadow for the bridge PWM generator: self-test, run gating,
// valley-aligned compare updates and fault bypass. Optional clamp: PWM_CTRL_CLAMP_EN.
module pwm_mode_ctrl #(
  parameter int CHK_WIN = 10000,
  parameter int BYP_LEN = 20000
) (
  input  logic           clk,
  input  logic           rst,
  pwm_mode_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_READY  = 3'd2,
    ST_RUN    = 3'd3,
    ST_BYPASS = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  localparam logic [15:0] CHK_LAST = 16'(4 * CHK_WIN - 1);
  localparam logic [15:0] BYP_LAST = 16'(BYP_LEN - 1);
  localparam logic [15:0] SMP0     = 16'(CHK_WIN / 2);
  localparam logic [15:0] SMP1     = 16'(CHK_WIN + CHK_WIN / 2);
  localparam logic [15:0] SMP2     = 16'(2 * CHK_WIN + CHK_WIN / 2);
  localparam logic [15:0] SMP3     = 16'(3 * CHK_WIN + CHK_WIN / 2);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  check_err_q, check_err_d;
  logic        check_ok_q, check_ok_d;
  logic        start_q, start_d;
  logic        check_q, check_d;
  logic        pass_q, pass_d;
  logic        syn_q, syn_d;
  logic [15:0] pose_q, pose_d;
  logic [15:0] nege_q, nege_d;
  logic [15:0] fre_q, fre_d;
  logic [15:0] sh_pose_q, sh_pose_d;
  logic [15:0] sh_nege_q, sh_nege_d;
  logic [15:0] sh_fre_q, sh_fre_d;
  logic        cfg_pend_q, cfg_pend_d;
  logic        load_active;
  logic [15:0] ld_pose, ld_nege;

`ifdef PWM_CTRL_CLAMP_EN
  // Keep compare words strictly below half the peak and never zero.
  function automatic logic [15:0] clamp_word(input logic [15:0] w, input logic [15:0] half);
    logic [15:0] r;
    r = w;
    if (w >= half) r = (half == 16'd0) ? 16'd0 : half - 16'd1;
    if (r == 16'd0) r = 16'd1;
    return r;
  endfunction

  always_comb begin
    ld_pose = clamp_word(sh_pose_q, {1'b0, sh_fre_q[15:1]});
    ld_nege = clamp_word(sh_nege_q, {1'b0, sh_fre_q[15:1]});
  end
`else
  always_comb begin
    ld_pose = sh_pose_q;
    ld_nege = sh_nege_q;
  end
`endif

  // Next-state logic; fault_in outranks every command, cmd_stop outranks start/check.
  always_comb begin
    state_d     = state_q;
    check_err_d = check_err_q;
    check_ok_d  = check_ok_q;
    load_active = 1'b0;
    if (bus.fault_in && (state_q != ST_BYPASS) && (state_q != ST_FAULT)) begin
      state_d = ST_BYPASS;
      if (state_q == ST_CHECK) check_ok_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!bus.cmd_stop && bus.cmd_check) begin
            state_d     = ST_CHECK;
            check_err_d = 4'd0;
            check_ok_d  = 1'b0;
          end
        end
        ST_CHECK: begin
          // Leg map per window: col1, col0, col3, col2.
          if ((cnt_q == SMP0) && !bus.col[1]) check_err_d[0] = 1'b1;
          if ((cnt_q == SMP1) && !bus.col[0]) check_err_d[1] = 1'b1;
          if ((cnt_q == SMP2) && !bus.col[3]) check_err_d[2] = 1'b1;
          if ((cnt_q == SMP3) && !bus.col[2]) check_err_d[3] = 1'b1;
          if (cnt_q == CHK_LAST) begin
            check_ok_d = (check_err_d == 4'd0);
            state_d    = check_ok_d ? ST_READY : ST_FAULT;
          end
        end
        ST_READY: begin
          if (!bus.cmd_stop && bus.cmd_start && (sh_fre_q != 16'd0)) begin
            state_d     = ST_RUN;
            load_active = 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.cmd_stop) begin
            state_d = ST_READY;
          end else if (cfg_pend_q && (bus.comp_tri == 16'd0)) begin
            load_active = 1'b1;
          end
        end
        ST_BYPASS: begin
          if (cnt_q == BYP_LAST) state_d = ST_FAULT;
        end
        ST_FAULT: begin
          if (bus.cmd_clear && !bus.fault_in) begin
            state_d     = ST_IDLE;
            check_err_d = 4'd0;
            check_ok_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath: shared counter, shadow capture, active-word loading and mode outputs.
  always_comb begin
    cnt_d = 16'd0;
    if ((state_d == state_q) && ((state_q == ST_CHECK) || (state_q == ST_BYPASS)))
      cnt_d = cnt_q + 16'd1;

    pose_d     = pose_q;
    nege_d     = nege_q;
    fre_d      = fre_q;
    cfg_pend_d = cfg_pend_q;
    if (load_active) begin
      pose_d     = ld_pose;
      nege_d     = ld_nege;
      fre_d      = sh_fre_q;
      cfg_pend_d = 1'b0;
    end

    sh_pose_d = sh_pose_q;
    sh_nege_d = sh_nege_q;
    sh_fre_d  = sh_fre_q;
    // A capture in the same cycle as an apply leaves the new value pending.
    if (bus.cfg_wr) begin
      sh_pose_d  = bus.pose_req;
      sh_nege_d  = bus.nege_req;
      sh_fre_d   = bus.fre_req;
      cfg_pend_d = 1'b1;
    end

    start_d = (state_d == ST_RUN);
    check_d = (state_d == ST_CHECK);
    pass_d  = (state_d == ST_BYPASS);
    syn_d   = (state_q == ST_READY) && (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      check_err_q <= 4'd0;
      check_ok_q  <= 1'b0;
      start_q     <= 1'b0;
      check_q     <= 1'b0;
      pass_q      <= 1'b0;
      syn_q       <= 1'b0;
      pose_q      <= 16'd0;
      nege_q      <= 16'd0;
      fre_q       <= 16'd0;
      sh_pose_q   <= 16'd0;
      sh_nege_q   <= 16'd0;
      sh_fre_q    <= 16'd0;
      cfg_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      check_err_q <= check_err_d;
      check_ok_q  <= check_ok_d;
      start_q     <= start_d;
      check_q     <= check_d;
      pass_q      <= pass_d;
      syn_q       <= syn_d;
      pose_q      <= pose_d;
      nege_q      <= nege_d;
      fre_q       <= fre_d;
      sh_pose_q   <= sh_pose_d;
      sh_nege_q   <= sh_nege_d;
      sh_fre_q    <= sh_fre_d;
      cfg_pend_q  <= cfg_pend_d;
    end
  end

  assign bus.start     = start_q;
  assign bus.check     = check_q;
  assign bus.pass      = pass_q;
  assign bus.syn       = syn_q;
  assign bus.pose      = pose_q;
  assign bus.nege      = nege_q;
  assign bus.fre       = fre_q;
  assign bus.state     = state_q;
  assign bus.check_ok  = check_ok_q;
  assign bus.check_err = check_err_q;
  assign bus.cfg_pend  = cfg_pend_q;

endmodule
